// File: rtl/contador_pkg.sv
// contador_pkg: shared FSM state encoding and step-direction constants for contador_seq
package contador_pkg;
    typedef enum logic [2:0] {IDLE, EVAL, STEP_HI, STEP_LO, FIN, FAIL} state_t;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin selector producing a one-hot grant
// req[1:0] in: requests; ptr in: requester favoured on contention; gnt[1:0] out: one-hot grant (0 when idle)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
    always_comb gnt = (req == 2'b11) ? (ptr ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/contador_seq.sv
// contador_seq: steps an external up/down counter toward a per-requester target and acknowledges the requester
// in: clk, rst (async, high), req[1:0], tgt0/tgt1 (targets), cuenta (counter value), full, empty
// out: nxt (step strobe), dir (1 = up), gnt[1:0] (one-hot grant), ack[1:0] (done pulse), err (unreachable), busy
module contador_seq
    import contador_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [W-1:0] tgt0,
    input  logic [W-1:0] tgt1,
    input  logic [W-1:0] cuenta,
    input  logic         full,
    input  logic         empty,
    output logic         nxt,
    output logic         dir,
    output logic [1:0]   gnt,
    output logic [1:0]   ack,
    output logic         err,
    output logic         busy
);
    state_t state_q, state_d;
    logic [W-1:0] tgt_q, tgt_d;
    logic ptr_q, ptr_d, nxt_q, nxt_d, dir_q, dir_d, err_q, err_d, busy_q, busy_d;
    logic [1:0] gnt_q, gnt_d, ack_q, ack_d, arb_gnt;

    rr_arb2 u_arb (.req(req), .ptr(ptr_q), .gnt(arb_gnt));

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        state_d = state_q;
        tgt_d = tgt_q;
        ptr_d = ptr_q;
        dir_d = dir_q;
        gnt_d = gnt_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = EVAL;
                gnt_d = arb_gnt;
                tgt_d = arb_gnt[1] ? tgt1 : tgt0;
            end
            EVAL: if (tgt_q > cuenta) begin
                dir_d = DIR_UP;
                state_d = full ? FAIL : STEP_HI;
            end else if (tgt_q < cuenta) begin
                dir_d = DIR_DOWN;
                state_d = empty ? FAIL : STEP_HI;
            end else begin
                state_d = FIN;
            end
            STEP_HI: state_d = STEP_LO;
            STEP_LO: state_d = EVAL;
            FIN, FAIL: begin
                state_d = IDLE;
                gnt_d = 2'b00;
                // hand priority to whichever requester was not just served
                ptr_d = ~gnt_q[1];
            end
            default: state_d = IDLE;
        endcase
        nxt_d = state_d == STEP_HI;
        ack_d = (state_d == FIN || state_d == FAIL) ? gnt_d : 2'b00;
        err_d = state_d == FAIL;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            tgt_q <= '0;
            ptr_q <= 1'b0;
            nxt_q <= 1'b0;
            dir_q <= DIR_DOWN;
            gnt_q <= 2'b00;
            ack_q <= 2'b00;
            err_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q <= tgt_d;
            ptr_q <= ptr_d;
            nxt_q <= nxt_d;
            dir_q <= dir_d;
            gnt_q <= gnt_d;
            ack_q <= ack_d;
            err_q <= err_d;
            busy_q <= busy_d;
        end

    assign nxt = nxt_q;
    assign dir = dir_q;
    assign gnt = gnt_q;
    assign ack = ack_q;
    assign err = err_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_contador_seq.sv
// tb_contador_seq: directed plus randomized bench for contador_seq with an external up/down counter model
module tb_contador_seq;
    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] req = 2'b00, tgt0 = 2'd0, tgt1 = 2'd0, cuenta = 2'd0;
    logic full, empty, force_full = 1'b0;
    logic nxt, dir, err, busy;
    logic [1:0] gnt, ack;
    int errors = 0, checks = 0, npulse = 0, dirbad = 0;
    logic exp_dir = 1'b0;
    logic ptr_m = 1'b0;
    logic [1:0] cnt_m = 2'd0;

    always #5 clk = ~clk;

    assign full = force_full | (cuenta == 2'd3);
    assign empty = cuenta == 2'd0;

    contador_seq #(.W(2)) dut (
        .clk(clk), .rst(rst), .req(req), .tgt0(tgt0), .tgt1(tgt1),
        .cuenta(cuenta), .full(full), .empty(empty),
        .nxt(nxt), .dir(dir), .gnt(gnt), .ack(ack), .err(err), .busy(busy)
    );

    // external saturating up/down counter
    always @(posedge clk)
        if (nxt) begin
            cuenta <= dir ? (cuenta == 2'd3 ? cuenta : cuenta + 2'd1) : (cuenta == 2'd0 ? cuenta : cuenta - 2'd1);
            npulse <= npulse + 1;
            if (dir !== exp_dir) dirbad <= dirbad + 1;
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    // Reference: a service from count c to target t takes |t-c| steps and acks 2+3|t-c| cycles
    // after the request is sampled; an upward move with full forced fails at once.
    task automatic expect_srv(input logic [1:0] g, input logic [1:0] t, input bit perturb, input string tag);
        int d, lat, k, p0, b0;
        logic e;
        d = (int'(t) > int'(cnt_m)) ? int'(t) - int'(cnt_m) : int'(cnt_m) - int'(t);
        e = force_full && (t > cnt_m);
        lat = e ? 2 : 2 + 3 * d;
        exp_dir = t > cnt_m;
        p0 = npulse;
        b0 = dirbad;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (perturb && k == 1) begin
                req = 2'b00;
                tgt0 = 2'($urandom);
                tgt1 = 2'($urandom);
            end
        end while (ack === 2'b00 && k < 64);
        chk({tag, ".ack"}, 32'(ack), 32'(g));
        chk({tag, ".lat"}, k, lat);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".err"}, 32'(err), 32'(e));
        chk({tag, ".steps"}, npulse - p0, e ? 0 : d);
        chk({tag, ".dir"}, dirbad - b0, 0);
        req = req & ~g;
        if (!e) cnt_m = t;
        ptr_m = g[0];
        chk({tag, ".cuenta"}, 32'(cuenta), 32'(cnt_m));
        @(posedge clk); #1;
        chk({tag, ".idle"}, 32'({ack, gnt, busy, err, nxt}), 0);
    endtask

    task automatic serve(input logic [1:0] r, input logic [1:0] t0, input logic [1:0] t1, input bit perturb, input string tag);
        logic [1:0] first;
        first = (r == 2'b11) ? (ptr_m ? 2'b10 : 2'b01) : r;
        req = r;
        tgt0 = t0;
        tgt1 = t1;
        expect_srv(first, first[1] ? t1 : t0, perturb && r != 2'b11, tag);
        if (r == 2'b11) expect_srv(~first, first[1] ? t0 : t1, 1'b0, {tag, "b"});
    endtask

    initial begin
        int k;
        #1;
        chk("reset.out", 32'({nxt, dir, gnt, ack, err, busy}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle.out", 32'({nxt, dir, gnt, ack, err, busy}), 0);
        serve(2'b01, 2'd3, 2'd0, 1'b0, "v1");
        serve(2'b10, 2'd0, 2'd3, 1'b0, "v2");
        serve(2'b11, 2'd1, 2'd2, 1'b0, "v3");
        serve(2'b01, 2'd1, 2'd0, 1'b0, "pre_v4");
        force_full = 1'b1;
        serve(2'b01, 2'd3, 2'd0, 1'b0, "v4");
        force_full = 1'b0;
        serve(2'b01, 2'd0, 2'd0, 1'b0, "pre_v5");
        req = 2'b01;
        tgt0 = 2'd3;
        k = 0;
        while (nxt !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("v5.nxt_seen", 32'(nxt), 1);
        rst = 1'b1;
        #1;
        chk("v5.rst_out", 32'({nxt, dir, gnt, ack, err, busy}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ptr_m = 1'b0;
        chk("v5.no_step", 32'(cuenta), 32'(cnt_m));
        expect_srv(2'b01, 2'd3, 1'b0, "v5");
        serve(2'b01, 2'd0, 2'd0, 1'b1, "v6");
        for (int i = 0; i < 25; i++)
            serve(2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
